// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tone_sequencer
// Description : Plays an 8-entry note table. Each entry selects a half-period
//               divider for a downstream tone generator plus a duration in
//               ticks; every note is followed by a fixed silent gap. Playback
//               can loop, be aborted, and the table can be rewritten at any
//               time (changes are picked up at the next LOAD of that entry).
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               start, abort    - begin playback from entry 0 / stop at once
//               loop_en         - replay from entry 0 after the last entry
//               last_idx        - index of the final entry
//               wr_en/addr/data - table write port
//                                 ({rest, divider[14:0], duration[7:0]})
//               divider         - latched half-period count
//               tone_en         - audible note playing
//               busy, done      - in LOAD/PLAY/GAP; completion pulse
//               note_idx        - entry currently loaded/playing
// Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
  parameter int TICK_DIV  = 25000,
  parameter int GAP_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        loop_en,
  input  logic [2:0]  last_idx,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [23:0] wr_data,
  output logic [14:0] divider,
  output logic        tone_en,
  output logic        busy,
  output logic        done,
  output logic [2:0]  note_idx
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [23:0]   r_table [8];
  logic [PW-1:0] r_presc;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]    r_dur_cnt;
  logic [14:0]   r_divider;
  logic          r_audible;
  logic [2:0]    r_note_idx;
  logic [23:0]   w_entry;
  logic          w_active;
  logic          w_tick;
  logic          w_play_end;
  logic          w_gap_end;

  assign w_entry    = r_table[r_note_idx];
  assign w_active   = (r_state == S_PLAY) || (r_state == S_GAP);
  assign w_tick     = w_active && (r_presc == TICK_LAST);
  assign w_play_end = w_tick && (r_dur_cnt == 8'd1);
  assign w_gap_end  = w_tick && (r_gap_cnt == GW'(1));

  // Note table: writable in any state; reads happen only in LOAD, so an
  // entry already latched into the datapath is never disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_table[i] <= '0;
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start && !abort) w_next = S_LOAD;
        S_LOAD: w_next = S_PLAY;
        S_PLAY: if (w_play_end) w_next = S_GAP;
        S_GAP: begin
          if (w_gap_end) begin
            // An index at or beyond last_idx is treated as the final entry.
            if (r_note_idx < last_idx || loop_en) w_next = S_LOAD;
            else                                  w_next = S_DONE;
          end
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: prescaler, duration/gap counters, latched note parameters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_gap_cnt  <= '0;
      r_dur_cnt  <= '0;
      r_divider  <= '0;
      r_audible  <= 1'b0;
      r_note_idx <= '0;
    end else begin
      // Restart the tick phase whenever PLAY or GAP is (re)entered.
      if (!w_active || (w_next != r_state) || w_tick) r_presc <= '0;
      else                                            r_presc <= r_presc + PW'(1);

      case (r_state)
        S_IDLE: begin
          if (start && !abort) r_note_idx <= '0;
        end
        S_LOAD: begin
          r_divider <= w_entry[22:8];
          r_dur_cnt <= (w_entry[7:0] == 8'd0) ? 8'd1 : w_entry[7:0];
          r_audible <= ~w_entry[23] & (w_entry[22:8] != 15'd0);
        end
        S_PLAY: begin
          if (w_tick) r_dur_cnt <= r_dur_cnt - 8'd1;
          r_gap_cnt <= GAP_LOAD;
        end
        S_GAP: begin
          if (w_tick) r_gap_cnt <= r_gap_cnt - GW'(1);
          if (w_next == S_LOAD)
            r_note_idx <= (r_note_idx < last_idx) ? r_note_idx + 3'd1 : 3'd0;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the registered state
  always_comb begin
    tone_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_LOAD:  busy = 1'b1;
      S_PLAY: begin
        busy    = 1'b1;
        tone_en = r_audible;
      end
      S_GAP:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign divider  = r_divider;
  assign note_idx = r_note_idx;

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000: clk cycles per duration tick (1 ms at 25 MHz); legal range >=2.
REQ-002 Parameter GAP_TICKS, default 10: silent ticks inserted after every note; legal range >=1.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request to play sequence from entry 0; sampled each cycle.
REQ-006 abort  in  1  stop playback immediately.
REQ-007 loop_en  in  1  replay from entry 0 after last entry; sampled at end of each GAP.
REQ-008 last_idx  in  3  index of final entry; sampled at end of each GAP.
REQ-009 wr_en  in  1  note table write strobe.
REQ-010 wr_addr  in  3  note table entry to write.
REQ-011 wr_data  in  24  entry: [23] rest, [22:8] divider, [7:0] duration in ticks.
REQ-012 divider  out  15  half-period count for the downstream divider-based tone generator (25 MHz/440 Hz/2 = 28409 for A4).
REQ-013 tone_en  out  1  tone generator enable; high only while an audible note plays.
REQ-014 busy  out  1  high in LOAD, PLAY, GAP.
REQ-015 done  out  1  one-cycle pulse on normal sequence completion.
REQ-016 note_idx  out  3  index of entry currently loaded/playing.

Function
REQ-017 Table: 8 x 24-bit registers; write on wr_en at any time, in any state; a write takes effect at the next LOAD of that entry; the entry already playing is unaffected.
REQ-018 FSM states: IDLE, LOAD, PLAY, GAP, DONE; each state has a registered output decode.
REQ-019 IDLE: start=1 and abort=0 -> LOAD, note_idx<=0; otherwise stay.
REQ-020 LOAD: exactly 1 cycle; latch divider<=entry[22:8], dur_cnt<=entry[7:0] (0 treated as 1), audible<=~entry[23] & (entry[22:8]!=0); -> PLAY.
REQ-021 Prescaler: cleared to 0 on entry to PLAY and to GAP; counts 0..TICK_DIV-1 and wraps; tick=1 when prescaler==TICK_DIV-1.
REQ-022 PLAY: on tick, dur_cnt decrements; on tick with dur_cnt==1 -> GAP; PLAY lasts exactly dur x TICK_DIV cycles.
REQ-023 tone_en = (state==PLAY) & audible; divider holds its latched value through GAP until the next LOAD.
REQ-024 GAP: lasts GAP_TICKS x TICK_DIV cycles; at the end, if note_idx!=last_idx -> note_idx+1, LOAD; else if loop_en -> note_idx<=0, LOAD; else -> DONE.
REQ-025 If last_idx < note_idx at the end of GAP, the block treats the current entry as final.
REQ-026 DONE: done=1 and busy=0 for 1 cycle -> IDLE.
REQ-027 abort=1 in any non-IDLE state -> IDLE next cycle; tone_en=0 and busy=0 from that cycle; no done pulse.
REQ-028 start while busy is ignored; start and abort in the same cycle in IDLE -> stay IDLE.
REQ-029 Duration arithmetic is 8-bit unsigned; max note length is 255 ticks; no wrap.

Reset
REQ-030 rst_n=0 asynchronously forces: state=IDLE, divider=0, tone_en=0, busy=0, done=0, note_idx=0, prescaler=0, dur_cnt=0, and all table entries to 0.
REQ-031 Reset mid-note silences tone_en in the same cycle rst_n falls; after release, the block waits in IDLE for start.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-032 Reset release -> all outputs 0; IDLE holds with start=0 for 100 cycles.
REQ-033 entry0={0,28409,3}, last_idx=0, start at cycle 0 -> LOAD at cycle 1; tone_en=1 and divider=28409 in cycles 2-13; GAP in cycles 14-17; done=1 only at cycle 18; busy=1 in cycles 1-17.
REQ-034 entry0 rest bit=1 or divider=0 -> same timing as REQ-033, tone_en never 1, done at cycle 18; duration=0 -> PLAY lasts 4 cycles.
REQ-035 abort at cycle 6 of REQ-033 -> cycle 7: tone_en=0, busy=0; no done pulse; a new start then plays from entry 0.
REQ-036 last_idx=1, loop_en=1 -> note_idx sequence 0,1,0,1 with no done; clear loop_en during note 1 -> done after that note's GAP.
REQ-037 start asserted while busy ignored; start+abort in IDLE -> no LOAD; wr_en to entry 1 while entry 1 plays -> new value heard on its next LOAD only.
